// File: rtl/alu_iter.sv
// alu_iter: iterative ALU with one-cycle logic/arith ops and bit-serial shifts over valid/ready channels.
// Define ALU_ITER_SLT_EN to add SLT (1000) and SLTU (1001); otherwise every 1xxx code returns 0.
module alu_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       ALU_ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   acc, acc_n, res_n, quick, shifted;
    logic [SHAMT_W-1:0] cnt, cnt_n, shamt;
    logic [1:0]         sop, sop_n;
    logic               accept, is_shift;

    assign shamt       = src2_i[SHAMT_W-1:0];
    assign in_ready_o  = state == IDLE;
    assign busy_o      = state != IDLE;
    assign out_valid_o = state == DONE;
    assign zero_o      = result_o == '0;
    assign accept      = in_valid_i && in_ready_o;
    assign is_shift    = ALU_ctrl_i[3:2] == 2'b01 && ALU_ctrl_i[1:0] != 2'b10;
    // sop holds ctrl[1:0]: 00 SLL, 01 SRL, 11 SRA (bit 1 selects sign fill)
    assign shifted     = sop == 2'b00 ? acc << 1 : {sop[1] & acc[WIDTH-1], acc[WIDTH-1:1]};

    always_comb begin
        quick = '0;
        case (ALU_ctrl_i)
            4'b0000: quick = src1_i & src2_i;
            4'b0001: quick = src1_i | src2_i;
            4'b0010: quick = src1_i + src2_i;
            4'b0011: quick = src1_i ^ src2_i;
            4'b0110: quick = src1_i - src2_i;
            4'b0100, 4'b0101, 4'b0111: quick = src1_i;
`ifdef ALU_ITER_SLT_EN
            4'b1000: quick = WIDTH'($signed(src1_i) < $signed(src2_i));
            4'b1001: quick = WIDTH'(src1_i < src2_i);
`endif
            default: quick = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        sop_n   = sop;
        res_n   = result_o;
        case (state)
            IDLE: if (accept) begin
                if (is_shift && shamt != '0) begin
                    state_n = SHIFT;
                    acc_n   = src1_i;
                    cnt_n   = shamt;
                    sop_n   = ALU_ctrl_i[1:0];
                end else begin
                    state_n = DONE;
                    res_n   = quick;
                end
            end
            SHIFT: begin
                acc_n = shifted;
                cnt_n = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    state_n = DONE;
                    res_n   = shifted;
                end
            end
            DONE: state_n = out_ready_i ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            sop      <= '0;
            result_o <= '0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            sop      <= sop_n;
            result_o <= res_n;
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed self-checking bench for alu_iter.
module tb_alu_iter;
    logic        clk_i = 0, rst_i = 1, in_valid_i = 0, out_ready_i = 1;
    logic [3:0]  ALU_ctrl_i = 0;
    logic [31:0] src1_i = 0, src2_i = 0;
    logic        in_ready_o, out_valid_o, zero_o, busy_o;
    logic [31:0] result_o;
    int          n_cmp = 0, n_err = 0;

    alu_iter dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .ALU_ctrl_i(ALU_ctrl_i), .src1_i(src1_i), .src2_i(src2_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .result_o(result_o), .zero_o(zero_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Drives one request at a negedge; returns 1 ns after the edge that accepts it.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        @(negedge clk_i);
        in_valid_i = 1; ALU_ctrl_i = op; src1_i = a; src2_i = b;
        while (!in_ready_o && guard < 100) begin @(negedge clk_i); guard++; end
        @(posedge clk_i); #1;
        in_valid_i = 0; src1_i = 32'hDEAD_BEEF; src2_i = 32'h0000_0003; ALU_ctrl_i = 4'b0101;
    endtask

    // Counts edges after the accept until out_valid_o rises (bounded).
    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!out_valid_o && n < max) begin @(posedge clk_i); #1; n++; end
    endtask

    task automatic consume();
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        @(posedge clk_i); #1;
        n_cmp++; if (out_valid_o !== 0 || in_ready_o !== 1 || busy_o !== 0) begin n_err++;
            $display("FAIL reset_ctl got v=%b r=%b b=%b want 0 1 0", out_valid_o, in_ready_o, busy_o); end
        n_cmp++; if (result_o !== 32'h0 || zero_o !== 1) begin n_err++;
            $display("FAIL reset_res got %h z=%b want 0 z=1", result_o, zero_o); end
        @(negedge clk_i); rst_i = 0;
    endtask

    task automatic test_add_wrap();
        int n;
        send(4'b0010, 32'hFFFF_FFFF, 32'h1);
        wait_valid(5, n);
        n_cmp++; if (n !== 0 || out_valid_o !== 1) begin n_err++;
            $display("FAIL add_latency got n=%0d v=%b want 0 1", n, out_valid_o); end
        n_cmp++; if (result_o !== 32'h0 || zero_o !== 1) begin n_err++;
            $display("FAIL add_result got %h z=%b want 00000000 z=1", result_o, zero_o); end
        consume();
        n_cmp++; if (out_valid_o !== 0 || in_ready_o !== 1) begin n_err++;
            $display("FAIL add_release got v=%b r=%b want 0 1", out_valid_o, in_ready_o); end
    endtask

    task automatic test_sub_xor();
        int n;
        send(4'b0110, 32'd5, 32'd7);
        wait_valid(5, n);
        n_cmp++; if (result_o !== 32'hFFFF_FFFE || zero_o !== 0 || n !== 0) begin n_err++;
            $display("FAIL sub got %h z=%b n=%0d want fffffffe z=0 n=0", result_o, zero_o, n); end
        consume();
        send(4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000);
        wait_valid(5, n);
        n_cmp++; if (result_o !== 32'h0F0F_F0F0) begin n_err++;
            $display("FAIL xor got %h want 0f0ff0f0", result_o); end
        consume();
        send(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0);
        wait_valid(5, n);
        n_cmp++; if (result_o !== 32'h0F00_0F00) begin n_err++;
            $display("FAIL and got %h want 0f000f00", result_o); end
        consume();
    endtask

    task automatic test_shift_right();
        int n;
        send(4'b0111, 32'h8000_0000, 32'd4);
        n_cmp++; if (in_ready_o !== 0 || busy_o !== 1 || out_valid_o !== 0) begin n_err++;
            $display("FAIL sra_busy got r=%b b=%b v=%b want 0 1 0", in_ready_o, busy_o, out_valid_o); end
        wait_valid(50, n);
        n_cmp++; if (n !== 4 || result_o !== 32'hF800_0000) begin n_err++;
            $display("FAIL sra got %h n=%0d want f8000000 n=4", result_o, n); end
        consume();
        send(4'b0101, 32'h8000_0000, 32'd4);
        wait_valid(50, n);
        n_cmp++; if (n !== 4 || result_o !== 32'h0800_0000) begin n_err++;
            $display("FAIL srl got %h n=%0d want 08000000 n=4", result_o, n); end
        consume();
    endtask

    task automatic test_sll();
        int n;
        send(4'b0100, 32'h1234_5678, 32'h0000_0020);
        wait_valid(50, n);
        n_cmp++; if (n !== 0 || result_o !== 32'h1234_5678) begin n_err++;
            $display("FAIL sll0 got %h n=%0d want 12345678 n=0", result_o, n); end
        consume();
        send(4'b0100, 32'h1, 32'd31);
        wait_valid(50, n);
        n_cmp++; if (n !== 31 || result_o !== 32'h8000_0000) begin n_err++;
            $display("FAIL sll31 got %h n=%0d want 80000000 n=31", result_o, n); end
        consume();
        send(4'b0100, 32'h0000_00C3, 32'd1);
        wait_valid(50, n);
        n_cmp++; if (n !== 1 || result_o !== 32'h0000_0186) begin n_err++;
            $display("FAIL sll1 got %h n=%0d want 00000186 n=1", result_o, n); end
        consume();
    endtask

    task automatic test_backpressure();
        int n;
        out_ready_i = 0;
        send(4'b0001, 32'h0000_00A0, 32'h0000_0005);
        wait_valid(5, n);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            in_valid_i = 1; ALU_ctrl_i = 4'b0010; src1_i = 32'h1111_0000 * (i + 1); src2_i = i;
            @(posedge clk_i); #1;
            n_cmp++; if (out_valid_o !== 1 || result_o !== 32'h0000_00A5 || in_ready_o !== 0) begin n_err++;
                $display("FAIL bp_hold%0d got v=%b %h r=%b want 1 000000a5 0", i, out_valid_o, result_o, in_ready_o); end
        end
        @(negedge clk_i); out_ready_i = 1; in_valid_i = 0;
        @(posedge clk_i); #1;
        n_cmp++; if (out_valid_o !== 0 || in_ready_o !== 1) begin n_err++;
            $display("FAIL bp_release got v=%b r=%b want 0 1", out_valid_o, in_ready_o); end
        repeat (3) @(posedge clk_i); #1;
        n_cmp++; if (out_valid_o !== 0 || busy_o !== 0) begin n_err++;
            $display("FAIL bp_noaccept got v=%b b=%b want 0 0", out_valid_o, busy_o); end
    endtask

    task automatic test_reset_mid_shift();
        int seen = 0;
        send(4'b0100, 32'h1, 32'd31);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1;
        @(posedge clk_i); #1;
        n_cmp++; if (out_valid_o !== 0 || result_o !== 32'h0 || in_ready_o !== 1 || busy_o !== 0) begin n_err++;
            $display("FAIL rst_mid got v=%b %h r=%b b=%b want 0 0 1 0", out_valid_o, result_o, in_ready_o, busy_o); end
        @(negedge clk_i); rst_i = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk_i); #1; if (out_valid_o) seen++; end
        n_cmp++; if (seen !== 0) begin n_err++;
            $display("FAIL rst_noresp got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_reserved();
        int n;
        send(4'b1010, 32'h1234_5678, 32'h1);
        wait_valid(5, n);
        n_cmp++; if (n !== 0 || result_o !== 32'h0 || zero_o !== 1) begin n_err++;
            $display("FAIL rsv got %h z=%b n=%0d want 0 z=1 n=0", result_o, zero_o, n); end
        consume();
`ifdef ALU_ITER_SLT_EN
        send(4'b1000, 32'hFFFF_FFFF, 32'h1);
        wait_valid(5, n);
        n_cmp++; if (n !== 0 || result_o !== 32'h1) begin n_err++;
            $display("FAIL slt got %h n=%0d want 1 n=0", result_o, n); end
        consume();
        send(4'b1001, 32'hFFFF_FFFF, 32'h1);
        wait_valid(5, n);
        n_cmp++; if (n !== 0 || result_o !== 32'h0) begin n_err++;
            $display("FAIL sltu got %h n=%0d want 0 n=0", result_o, n); end
        consume();
`else
        send(4'b1000, 32'hFFFF_FFFF, 32'h1);
        wait_valid(5, n);
        n_cmp++; if (n !== 0 || result_o !== 32'h0 || zero_o !== 1) begin n_err++;
            $display("FAIL slt_off got %h z=%b want 0 z=1", result_o, zero_o); end
        consume();
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        test_reset();
        test_add_wrap();
        test_sub_xor();
        test_shift_right();
        test_sll();
        test_backpressure();
        test_reset_mid_shift();
        test_reserved();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
